// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: host/datapath-facing bundle of the layer sequencer.
//   master modport: the environment (host + weight stores + datapath) that
//                   drives start/stop/weight_valid/layer_done and observes status.
//   slave modport : the layer_sequencer itself.
// Signals:
//   start, stop        host control (stop is a synchronous abort)
//   weight_valid       AND of all weight_store valid outputs
//   layer_done         one-cycle pulse from the datapath, current layer finished
//   cs[2:0]            shared layer-state code
//   run                level, datapath may compute while high
//   busy, done, err    status (done is a one-cycle pulse, err is sticky)
//   layer_idx[2:0]     current layer index
//   run_cycles[15:0]   RUN length of the last completed layer (0 when not built)
interface layer_sequencer_if;
  logic        start;
  logic        stop;
  logic        weight_valid;
  logic        layer_done;
  logic [2:0]  cs;
  logic        run;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  layer_idx;
  logic [15:0] run_cycles;

  modport master (
    output start, stop, weight_valid, layer_done,
    input  cs, run, busy, done, err, layer_idx, run_cycles
  );

  modport slave (
    input  start, stop, weight_valid, layer_done,
    output cs, run, busy, done, err, layer_idx, run_cycles
  );
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: inference controller stepping conv layers 0..NUM_CONV-1 and
// then the affine layer. For each layer it drives the shared cs code, waits out
// a blanking window, waits for weight_valid, raises run and waits for
// layer_done before advancing.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   sif         layer_sequencer_if.slave (start/stop/weight_valid/layer_done in,
//               cs/run/busy/done/err/layer_idx/run_cycles out, all registered)
//   dbg_state   current FSM state (0 IDLE, 1 LOAD, 2 RUN, 3 DONE)
// Optional feature macro: LAYER_CYCLE_COUNT_EN
//   defined   -> per-layer RUN cycle counter, latched into run_cycles on layer_done
//   undefined -> run_cycles tied to 16'h0000
//
// Handshake: weight_valid is a level qualifier, only honoured in LOAD once the
// blanking counter has reached zero (earlier values may be stale from the
// previous cs). run is the grant; the datapath answers with one layer_done
// pulse while run is high, and run drops on the following edge.

`ifndef LAYER0
`define LAYER0 3'd0
`endif
`ifndef LAYER1
`define LAYER1 3'd1
`endif
`ifndef LAYER2
`define LAYER2 3'd2
`endif
`ifndef LAYER3
`define LAYER3 3'd3
`endif
`ifndef AFFINE
`define AFFINE 3'd4
`endif

module layer_sequencer #(
  parameter int unsigned NUM_CONV     = 4,
  parameter int unsigned BLANK_CYCLES = 3,
  parameter logic [2:0]  IDLE_CS      = 3'd7
) (
  input  logic               clk,
  input  logic               rst,
  layer_sequencer_if.slave   sif,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_RUN = 2'd2, ST_DONE = 2'd3} state_e;

  localparam logic [2:0] AFFINE_IDX   = 3'(NUM_CONV);
  localparam logic [7:0] BLANK_RELOAD = 8'(BLANK_CYCLES);

  function automatic logic [2:0] conv_code(input logic [2:0] idx);
    case (idx)
      3'd0:    conv_code = `LAYER0;
      3'd1:    conv_code = `LAYER1;
      3'd2:    conv_code = `LAYER2;
      default: conv_code = `LAYER3;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  cs_q, cs_d;
  logic        run_q, run_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  blank_q, blank_d;
  logic        wv_q, wv_d;
  logic [2:0]  idx_next;

  assign idx_next = idx_q + 3'd1;
  assign wv_d     = sif.weight_valid;

  // State register (all registered outputs live here too).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cs_q    <= IDLE_CS;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= 3'd0;
      blank_q <= 8'd0;
      wv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      blank_q <= blank_d;
      wv_q    <= wv_d;
    end
  end

  // Next-state logic. stop outranks layer_done and weight_valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (sif.start && !sif.stop) state_d = ST_LOAD;
      ST_LOAD: begin
        if (sif.stop)                                state_d = ST_IDLE;
        else if (blank_q == 8'd0 && sif.weight_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (sif.stop)            state_d = ST_IDLE;
        else if (sif.layer_done) state_d = (idx_q == AFFINE_IDX) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath-register logic.
  always_comb begin
    cs_d    = cs_q;
    run_d   = run_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    idx_d   = idx_q;
    blank_d = blank_q;
    case (state_q)
      ST_IDLE: begin
        if (sif.start && !sif.stop) begin
          cs_d    = `LAYER0;
          idx_d   = 3'd0;
          blank_d = BLANK_RELOAD;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (sif.stop) begin
          cs_d    = IDLE_CS;
          run_d   = 1'b0;
          busy_d  = 1'b0;
          blank_d = 8'd0;
        end else begin
          if (blank_q != 8'd0) blank_d = blank_q - 8'd1;
          if (sif.layer_done) err_d = 1'b1;
          if (blank_q == 8'd0 && sif.weight_valid) run_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (sif.stop) begin
          cs_d    = IDLE_CS;
          run_d   = 1'b0;
          busy_d  = 1'b0;
          blank_d = 8'd0;
        end else if (sif.layer_done) begin
          run_d = 1'b0;
          if (idx_q != AFFINE_IDX) begin
            idx_d   = idx_next;
            cs_d    = (idx_next == AFFINE_IDX) ? `AFFINE : conv_code(idx_next);
            blank_d = BLANK_RELOAD;
          end else begin
            cs_d   = IDLE_CS;
            done_d = 1'b1;
          end
        end else if (wv_q && !sif.weight_valid) begin
          // Weights vanished under a running layer; flag it but keep running.
          err_d = 1'b1;
        end
      end
      ST_DONE: begin
        busy_d = 1'b0;
        run_d  = 1'b0;
      end
      default: ;
    endcase
  end

  assign sif.cs        = cs_q;
  assign sif.run       = run_q;
  assign sif.busy      = busy_q;
  assign sif.done      = done_q;
  assign sif.err       = err_q;
  assign sif.layer_idx = idx_q;
  assign dbg_state     = state_q;

`ifdef LAYER_CYCLE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] rc_q, rc_d;
  logic [15:0] cnt_inc;

  // cnt_q counts RUN cycles already elapsed; the latched value includes the
  // layer_done cycle itself, hence the use of the incremented value.
  always_comb begin
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    if (state_q == ST_LOAD && state_d == ST_RUN) begin
      cnt_d = 16'd0;
    end else if (state_q == ST_RUN && !sif.stop) begin
      cnt_d = cnt_inc;
      if (sif.layer_done) rc_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
      rc_q  <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
      rc_q  <= rc_d;
    end
  end

  assign sif.run_cycles = rc_q;
`else
  assign sif.run_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed bench for layer_sequencer. A NUM_CONV=4 instance
// carries most scenarios, with a cs scoreboard queue; a NUM_CONV=1 instance
// covers the shortest sequence.
module tb_layer_sequencer;

  localparam logic [2:0] C_L0 = 3'd0, C_L1 = 3'd1, C_L2 = 3'd2, C_L3 = 3'd3;
  localparam logic [2:0] C_AFF = 3'd4, C_IDLE = 3'd7;
  localparam int BLANK = 3;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] dbg4, dbg1;
  layer_sequencer_if bus4 ();
  layer_sequencer_if bus1 ();

  layer_sequencer #(.NUM_CONV(4), .BLANK_CYCLES(3), .IDLE_CS(3'd7)) dut (
    .clk(clk), .rst(rst), .sif(bus4), .dbg_state(dbg4)
  );
  layer_sequencer #(.NUM_CONV(1), .BLANK_CYCLES(3), .IDLE_CS(3'd7)) dut1 (
    .clk(clk), .rst(rst), .sif(bus1), .dbg_state(dbg1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // scoreboard of expected cs codes for dut (NUM_CONV=4)
  logic [2:0] exp_q[$];
  logic [2:0] cs_prev   = 3'd7;
  logic       run_prev  = 1'b0;
  logic       done_prev = 1'b0;
  int         run_rises   = 0;
  int         done_pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus4.cs !== cs_prev) begin
      check("cs_change_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("cs_seq", 32'(bus4.cs), 32'(exp_q.pop_front()));
    end
    if (bus4.run === 1'b1 && run_prev !== 1'b1) run_rises++;
    if (bus4.done === 1'b1 && done_prev !== 1'b1) done_pulses++;
    cs_prev   = bus4.cs;
    run_prev  = bus4.run;
    done_prev = bus4.done;
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
  endtask

  task automatic wait_run(output int k);
    k = 0;
    while (bus4.run !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    check("run_within_budget", 32'(k < 30), 32'd1);
  endtask

  // Called at the first cycle run is visible; keeps run high n_high cycles.
  task automatic finish_layer(input int n_high, input logic drop_wv);
    repeat (n_high - 1) tick();
    bus4.layer_done = 1'b1;
    if (drop_wv) bus4.weight_valid = 1'b0;
    tick();
    bus4.layer_done = 1'b0;
  endtask

  task automatic check_rc(input string tag, input int n);
`ifdef LAYER_CYCLE_COUNT_EN
    check(tag, 32'(bus4.run_cycles), 32'(n));
`else
    check(tag, 32'(bus4.run_cycles), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int done_before;
    bus4.start = 1'b0; bus4.stop = 1'b0; bus4.weight_valid = 1'b0; bus4.layer_done = 1'b0;
    bus1.start = 1'b0; bus1.stop = 1'b0; bus1.weight_valid = 1'b0; bus1.layer_done = 1'b0;
    #1 rst = 1'b1;
    repeat (2) tick();

    // reset state
    check("rst_cs",    32'(bus4.cs), 32'(C_IDLE));
    check("rst_run",   32'(bus4.run), 32'd0);
    check("rst_busy",  32'(bus4.busy), 32'd0);
    check("rst_done",  32'(bus4.done), 32'd0);
    check("rst_err",   32'(bus4.err), 32'd0);
    check("rst_idx",   32'(bus4.layer_idx), 32'd0);
    check("rst_rc",    32'(bus4.run_cycles), 32'd0);
    check("rst_state", 32'(dbg4), 32'd0);
    check("rst1_cs",   32'(bus1.cs), 32'(C_IDLE));
    rst = 1'b0;
    tick();

    // 1: full sequence, valid 5 cycles after each cs change, done 10 cycles after run
    exp_q.push_back(C_L0); exp_q.push_back(C_L1); exp_q.push_back(C_L2);
    exp_q.push_back(C_L3); exp_q.push_back(C_AFF); exp_q.push_back(C_IDLE);
    run_rises = 0; done_pulses = 0;
    pulse_start();
    check("t1_busy", 32'(bus4.busy), 32'd1);
    for (int l = 0; l < 5; l++) begin
      check("t1_layer_idx", 32'(bus4.layer_idx), 32'(l));
      repeat (5) tick();
      check("t1_run_low_without_valid", 32'(bus4.run), 32'd0);
      bus4.weight_valid = 1'b1;
      wait_run(k);
      check("t1_run_delay", 32'(k), 32'd1);
      finish_layer(11, 1'b1);
      check_rc("t1_run_cycles", 11);
      check("t1_run_fell", 32'(bus4.run), 32'd0);
    end
    check("t1_done_pulse", 32'(bus4.done), 32'd1);
    check("t1_done_busy", 32'(bus4.busy), 32'd1);
    tick();
    check("t1_done_cleared", 32'(bus4.done), 32'd0);
    check("t1_idle_busy", 32'(bus4.busy), 32'd0);
    check("t1_run_windows", 32'(run_rises), 32'd5);
    check("t1_done_count", 32'(done_pulses), 32'd1);
    check("t1_err", 32'(bus4.err), 32'd0);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // 2: weight_valid constantly high; stale valid must not shorten blanking
    bus4.weight_valid = 1'b1;
    tick();
    exp_q.push_back(C_L0); exp_q.push_back(C_L1); exp_q.push_back(C_L2);
    exp_q.push_back(C_L3); exp_q.push_back(C_AFF); exp_q.push_back(C_IDLE);
    pulse_start();
    for (int l = 0; l < 5; l++) begin
      wait_run(k);
      check("t2_run_after_cs", 32'(k), 32'(BLANK + 1));
      finish_layer(3, 1'b0);
    end
    check("t2_done_pulse", 32'(bus4.done), 32'd1);
    tick();
    check("t2_err", 32'(bus4.err), 32'd0);

    // 3: stop in RUN of layer 2 coinciding with layer_done
    exp_q.push_back(C_L0); exp_q.push_back(C_L1); exp_q.push_back(C_L2); exp_q.push_back(C_IDLE);
    pulse_start();
    for (int l = 0; l < 2; l++) begin
      wait_run(k);
      finish_layer(3, 1'b0);
    end
    wait_run(k);
    done_before = done_pulses;
    bus4.stop = 1'b1; bus4.layer_done = 1'b1;
    tick();
    bus4.stop = 1'b0; bus4.layer_done = 1'b0;
    check("t3_stop_cs", 32'(bus4.cs), 32'(C_IDLE));
    check("t3_stop_run", 32'(bus4.run), 32'd0);
    check("t3_stop_busy", 32'(bus4.busy), 32'd0);
    check("t3_stop_done", 32'(bus4.done), 32'd0);
    check("t3_stop_idx", 32'(bus4.layer_idx), 32'd2);
    check("t3_stop_state", 32'(dbg4), 32'd0);
    repeat (3) tick();
    check("t3_no_done", 32'(done_pulses), 32'(done_before));
    exp_q.push_back(C_L0);
    pulse_start();
    check("t3_restart_idx", 32'(bus4.layer_idx), 32'd0);
    check("t3_restart_busy", 32'(bus4.busy), 32'd1);

    // 4: layer_done during LOAD of layer 1 -> sticky err, no advance
    wait_run(k);
    exp_q.push_back(C_L1);
    finish_layer(3, 1'b0);
    bus4.layer_done = 1'b1;
    tick();
    bus4.layer_done = 1'b0;
    check("t4_err_set", 32'(bus4.err), 32'd1);
    check("t4_no_advance_idx", 32'(bus4.layer_idx), 32'd1);
    check("t4_no_run", 32'(bus4.run), 32'd0);
    check("t4_state_load", 32'(dbg4), 32'd1);
    wait_run(k);
    check("t4_run_delay", 32'(k), 32'(BLANK));
    exp_q.push_back(C_L2);
    finish_layer(3, 1'b0);
    check("t4_err_sticky", 32'(bus4.err), 32'd1);
    exp_q.push_back(C_IDLE);
    bus4.stop = 1'b1;
    tick();
    bus4.stop = 1'b0;
    check("t4_err_after_stop", 32'(bus4.err), 32'd1);
    bus4.start = 1'b1; bus4.stop = 1'b1;
    tick();
    bus4.start = 1'b0; bus4.stop = 1'b0;
    check("t4_start_stop_busy", 32'(bus4.busy), 32'd0);
    check("t4_start_stop_err", 32'(bus4.err), 32'd1);
    exp_q.push_back(C_L0);
    pulse_start();
    check("t4_err_cleared", 32'(bus4.err), 32'd0);

    // weight_valid falling during RUN -> err, run continues
    wait_run(k);
    bus4.weight_valid = 1'b0;
    tick();
    bus4.weight_valid = 1'b1;
    check("t4_wv_drop_err", 32'(bus4.err), 32'd1);
    check("t4_wv_drop_run", 32'(bus4.run), 32'd1);
    exp_q.push_back(C_IDLE);
    bus4.stop = 1'b1;
    tick();
    bus4.stop = 1'b0;

    // 5: NUM_CONV=1 instance
    bus1.weight_valid = 1'b1;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    check("t5_cs0", 32'(bus1.cs), 32'(C_L0));
    check("t5_idx0", 32'(bus1.layer_idx), 32'd0);
    for (int l = 0; l < 2; l++) begin
      k = 0;
      while (bus1.run !== 1'b1 && k < 30) begin tick(); k++; end
      check("t5_run_delay", 32'(k), 32'(BLANK + 1));
      bus1.layer_done = 1'b1;
      tick();
      bus1.layer_done = 1'b0;
      if (l == 0) begin
        check("t5_cs_aff", 32'(bus1.cs), 32'(C_AFF));
        check("t5_idx1", 32'(bus1.layer_idx), 32'd1);
      end
    end
    check("t5_cs_idle", 32'(bus1.cs), 32'(C_IDLE));
    check("t5_done", 32'(bus1.done), 32'd1);
    tick();
    check("t5_busy_off", 32'(bus1.busy), 32'd0);

    // 6: 20-cycle run window, then asynchronous reset mid-RUN
    exp_q.push_back(C_L0);
    pulse_start();
    wait_run(k);
    exp_q.push_back(C_L1);
    finish_layer(20, 1'b0);
    check_rc("t6_run_cycles_20", 20);
    wait_run(k);
    bus4.weight_valid = 1'b0;
    tick();
    bus4.weight_valid = 1'b1;
    check("t6_err_before_rst", 32'(bus4.err), 32'd1);
    repeat (5) tick();
    exp_q.push_back(C_IDLE);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_cs", 32'(bus4.cs), 32'(C_IDLE));
    check("t6_rst_run", 32'(bus4.run), 32'd0);
    check("t6_rst_busy", 32'(bus4.busy), 32'd0);
    check("t6_rst_err", 32'(bus4.err), 32'd0);
    check("t6_rst_idx", 32'(bus4.layer_idx), 32'd0);
    check("t6_rst_rc", 32'(bus4.run_cycles), 32'd0);
    check("t6_rst_state", 32'(dbg4), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
